// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing defaults and constants for the integer register file.
//   DEF_DATA_W  - default register width in bits
//   DEF_REG_NUM - default number of architectural registers (x0 included)
//   DEF_ADDR_W  - default register address width, clog2(DEF_REG_NUM)
//   X0_ADDR     - address of the hard-wired zero register, shared with decode
package regfile_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_REG_NUM = 32;
    localparam int DEF_ADDR_W  = 5;

    localparam logic [DEF_ADDR_W-1:0] X0_ADDR = '0;

endpackage

// File: rtl/regfile_scoreboard.sv
// reg_scoreboard: pending-write (busy) tracker for long-latency destinations.
// It raises stall when decode reads a register whose load result has not yet
// been written back, unless that result is being written back this very cycle.
// Ports:
//   clk         - system clock, rising edge
//   rst         - synchronous active-high reset, clears every busy bit
//   pend_set    - mark pend_addr as pending (load leaving execute)
//   pend_addr   - destination to mark pending
//   we          - write-back enable, clears the busy bit of wr_addr
//   wr_addr     - write-back destination
//   rs1_addr    - decode source address 1
//   rs2_addr    - decode source address 2
//   stall       - decode must hold
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pend_set,
    input  logic [ADDR_W-1:0] pend_addr,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic              stall
);

    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_next;
    logic               fwd1;
    logic               fwd2;

    // A new load to the same register supersedes an older write, so a set
    // wins over a clear at the same index. x0 can never become busy.
    always_comb begin
        busy_next = busy;
        for (int k = 1; k < REG_NUM; k++) begin
            if (pend_set && (pend_addr == ADDR_W'(k))) begin
                busy_next[k] = 1'b1;
            end else if (we && (wr_addr == ADDR_W'(k))) begin
                busy_next[k] = 1'b0;
            end
        end
        busy_next[0] = 1'b0;
    end

    // Busy vector register; reset forgets any load in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // A busy source whose value is arriving on the write-back port this cycle
    // is satisfied by forwarding, so it does not stall.
    always_comb begin
        fwd1  = we && (wr_addr == rs1_addr);
        fwd2  = we && (wr_addr == rs2_addr);
        stall = (busy[rs1_addr] && (rs1_addr != X0_ADDR) && !fwd1) ||
                (busy[rs2_addr] && (rs2_addr != X0_ADDR) && !fwd2);
    end

endmodule

// File: rtl/regfile.sv
// regfile: integer register file with two combinational read ports, one
// write-back port with same-cycle write-to-read forwarding, and a pending-load
// scoreboard that stalls decode on a still-pending source.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   rs1_addr_i   - read port 1 address       rs1_data_o - read port 1 data
//   rs2_addr_i   - read port 2 address       rs2_data_o - read port 2 data
//   we_i         - write-back enable
//   wr_addr_i    - write-back destination    wr_data_i  - write-back data
//   pend_set_i   - mark pend_addr_i pending  pend_addr_i - pending destination
//   stall_o      - a source register is pending
// Optional (macro REGFILE_DEBUG_PORT_EN):
//   dbg_addr_i   - debug read address
//   dbg_data_o   - registered debug read data, stored array only, 1-cycle latency
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int REG_NUM = DEF_REG_NUM,
    parameter int ADDR_W  = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1_addr_i,
    input  logic [ADDR_W-1:0] rs2_addr_i,
    output logic [DATA_W-1:0] rs1_data_o,
    output logic [DATA_W-1:0] rs2_data_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              pend_set_i,
    input  logic [ADDR_W-1:0] pend_addr_i,
    output logic              stall_o
`ifdef REGFILE_DEBUG_PORT_EN
    ,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o
`endif
);

    logic [DATA_W-1:0] regs [REG_NUM];

    // Register array. x0 is never written so it stays at its reset value;
    // the read paths force it to zero regardless.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < REG_NUM; k++) begin
                regs[k] <= '0;
            end
        end else if (we_i && (wr_addr_i != X0_ADDR)) begin
            regs[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read ports. A write landing on the same address this
    // cycle is forwarded so decode sees the value without waiting an edge.
    always_comb begin
        if (rs1_addr_i == X0_ADDR) begin
            rs1_data_o = '0;
        end else if (we_i && (wr_addr_i == rs1_addr_i)) begin
            rs1_data_o = wr_data_i;
        end else begin
            rs1_data_o = regs[rs1_addr_i];
        end

        if (rs2_addr_i == X0_ADDR) begin
            rs2_data_o = '0;
        end else if (we_i && (wr_addr_i == rs2_addr_i)) begin
            rs2_data_o = wr_data_i;
        end else begin
            rs2_data_o = regs[rs2_addr_i];
        end
    end

    reg_scoreboard #(
        .REG_NUM (REG_NUM),
        .ADDR_W  (ADDR_W)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .pend_set  (pend_set_i),
        .pend_addr (pend_addr_i),
        .we        (we_i),
        .wr_addr   (wr_addr_i),
        .rs1_addr  (rs1_addr_i),
        .rs2_addr  (rs2_addr_i),
        .stall     (stall_o)
    );

`ifdef REGFILE_DEBUG_PORT_EN
    // Debug read sees only the committed array contents, one edge late.
    always_ff @(posedge clk) begin
        if (rst) begin
            dbg_data_o <= '0;
        end else if (dbg_addr_i == X0_ADDR) begin
            dbg_data_o <= '0;
        end else begin
            dbg_data_o <= regs[dbg_addr_i];
        end
    end
`endif

endmodule
